// File: rtl/mux8_rr_sched.sv
// ============================================================================
// mux8_rr_sched : round-robin scheduler driving a shared 8:1 mux select
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mux8_rr_sched #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [7:0]        req,
   input  logic [HOLD_W-1:0] hold_len,
   output logic [7:0]        gnt,
   output logic [2:0]        sel,
   output logic              sel_valid,
   output logic              grant_start
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state, state_d;
   logic [2:0]        ptr, ptr_d, sel_d, base, win, idx;
   logic [HOLD_W-1:0] cnt, cnt_d, limit, limit_d;
   logic [7:0]        gnt_d, cand;
   logic              found, release_now, grant_start_d;

   // Search base is the post-release pointer while granted, so a release and
   // the following re-arbitration happen in the same edge.
   assign base = (state == GRANT) ? (sel + 3'd1) : ptr;
   assign cand = en ? req : 8'h00;

   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = base + 3'(k);
         if (cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign release_now = (state == GRANT) && (!req[sel] || (cnt == limit) || !en);

   always_comb begin
      state_d       = state;
      ptr_d         = ptr;
      cnt_d         = cnt;
      limit_d       = limit;
      gnt_d         = gnt;
      sel_d         = sel;
      grant_start_d = 1'b0;

      if (state == GRANT && !release_now) begin
         cnt_d = cnt + 1'b1;
      end

      if (release_now) begin
         ptr_d = sel + 3'd1;
      end

      if ((state == IDLE || release_now) && found) begin
         state_d       = GRANT;
         gnt_d         = 8'h01 << win;
         sel_d         = win;
         grant_start_d = 1'b1;
         cnt_d         = HOLD_W'(1);
         limit_d       = (hold_len == '0) ? HOLD_W'(1) : hold_len;
      end else if (release_now) begin
         state_d = IDLE;
         gnt_d   = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd0;
         cnt         <= '0;
         limit       <= '0;
         gnt         <= 8'h00;
         sel         <= 3'd0;
         grant_start <= 1'b0;
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         cnt         <= cnt_d;
         limit       <= limit_d;
         gnt         <= gnt_d;
         sel         <= sel_d;
         grant_start <= grant_start_d;
      end
   end

   assign sel_valid = |gnt;

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_sched.sv
// ============================================================================
// tb_mux8_rr_sched : directed + randomized bench with a behavioural model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mux8_rr_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [7:0] req = 8'h00;
   logic [3:0] hold_len = 4'd4;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       sel_valid;
   logic       grant_start;

   int checks = 0;
   int errors = 0;

   mux8_rr_sched #(.HOLD_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .hold_len    (hold_len),
      .gnt         (gnt),
      .sel         (sel),
      .sel_valid   (sel_valid),
      .grant_start (grant_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who holds the channel, for how long, and where the
   // circular search starts next.
   bit m_busy = 1'b0;
   int m_g    = 0;
   int m_age  = 0;
   int m_lim  = 0;
   int m_ptr  = 0;
   int m_sel  = 0;
   bit m_gs   = 1'b0;

   function automatic int pick(input logic [7:0] r, input int from);
      for (int k = 0; k < 8; k++) begin
         if (r[(from + k) % 8]) return (from + k) % 8;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_g = 0; m_age = 0; m_lim = 0; m_ptr = 0; m_sel = 0; m_gs = 1'b0;
      end else begin
         int  w;
         bit  done;
         m_gs = 1'b0;
         if (m_busy) begin
            done = !en || !req[m_g] || (m_age >= m_lim);
            if (done) begin
               m_ptr  = (m_g + 1) % 8;
               m_busy = 1'b0;
            end else begin
               m_age++;
            end
         end
         if (!m_busy) begin
            w = en ? pick(req, m_ptr) : -1;
            if (w >= 0) begin
               m_busy = 1'b1;
               m_g    = w;
               m_sel  = w;
               m_age  = 1;
               m_lim  = (hold_len == 0) ? 1 : int'(hold_len);
               m_gs   = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_gnt", {24'h0, gnt}, m_busy ? (32'h1 << m_g) : 32'h0);
      chk("model_sel", {29'h0, sel}, m_sel);
      chk("model_sel_valid", {31'h0, sel_valid}, {31'h0, m_busy});
      chk("model_grant_start", {31'h0, grant_start}, {31'h0, m_gs});
   end

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      req = 8'h00;
      en  = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Reset mid-grant, then first grant after reset
      repeat (2) @(negedge clk);
      chk("reset_gnt", {24'h0, gnt}, 32'h0);
      rst_n = 1'b1; req = 8'h10; hold_len = 4'd4;
      @(negedge clk);
      chk("t1_gnt_10", {24'h0, gnt}, 32'h10);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_gnt", {24'h0, gnt}, 32'h0);
      chk("t1_async_sel", {29'h0, sel}, 32'h0);
      chk("t1_async_valid", {31'h0, sel_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; req = 8'h01;
      @(negedge clk);
      chk("t1_gnt_01", {24'h0, gnt}, 32'h01);
      chk("t1_sel_0", {29'h0, sel}, 32'h0);
      chk("t1_gs", {31'h0, grant_start}, 32'h1);

      // Single requester with hold limit 3: re-grant every third cycle
      do_reset();
      req = 8'h08; hold_len = 4'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t2_gnt", {24'h0, gnt}, 32'h08);
         chk("t2_sel", {29'h0, sel}, 32'd3);
         chk("t2_gs", {31'h0, grant_start}, (i % 3 == 0) ? 32'h1 : 32'h0);
         chk("t2_valid", {31'h0, sel_valid}, 32'h1);
      end

      // Full contention, hold 1
      do_reset();
      req = 8'hFF; hold_len = 4'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_sel", {29'h0, sel}, i % 8);
         chk("t3_gs", {31'h0, grant_start}, 32'h1);
         chk("t3_valid", {31'h0, sel_valid}, 32'h1);
      end

      // Early release hands over with no gap
      do_reset();
      req = 8'h24; hold_len = 4'd4;
      @(negedge clk);
      chk("t4_gnt_a", {24'h0, gnt}, 32'h04);
      @(negedge clk);
      chk("t4_gnt_b", {24'h0, gnt}, 32'h04);
      req = 8'h20;
      @(negedge clk);
      chk("t4_gnt_c", {24'h0, gnt}, 32'h20);
      chk("t4_sel_c", {29'h0, sel}, 32'd5);
      chk("t4_gs_c", {31'h0, grant_start}, 32'h1);

      // Pointer wrap 7 -> 0
      do_reset();
      req = 8'h80; hold_len = 4'd1;
      @(negedge clk);
      chk("t5_gnt_80", {24'h0, gnt}, 32'h80);
      req = 8'h81;
      @(negedge clk);
      chk("t5_gnt_01", {24'h0, gnt}, 32'h01);
      chk("t5_sel_0", {29'h0, sel}, 32'h0);
      @(negedge clk);
      chk("t5_gnt_80b", {24'h0, gnt}, 32'h80);

      // hold_len 0 acts as 1; enable drop ends a grant
      do_reset();
      req = 8'h02; hold_len = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_gnt", {24'h0, gnt}, 32'h02);
         chk("t6_gs", {31'h0, grant_start}, 32'h1);
      end
      hold_len = 4'd7;
      @(negedge clk);
      chk("t6_gs_long", {31'h0, grant_start}, 32'h1);
      @(negedge clk);
      chk("t6_cycle2_gs", {31'h0, grant_start}, 32'h0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_en_gnt", {24'h0, gnt}, 32'h0);
         chk("t6_en_valid", {31'h0, sel_valid}, 32'h0);
         chk("t6_en_sel", {29'h0, sel}, 32'd1);
      end
      en = 1'b1;

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(299) == 0) do_reset();
         @(negedge clk);
         en = ($urandom_range(15) != 0);
         if ($urandom_range(2) == 0) begin
            case ($urandom_range(3))
               0:       req = 8'h00;
               1:       req = 8'h01 << $urandom_range(7);
               default: req = 8'($urandom);
            endcase
         end
         hold_len = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(3));
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 mux output channel among 8 requesters.
- Arbitrates `req[7:0]` and drives the registered 3-bit select to the mux: `sel[2]`→s2, `sel[1]`→s1, `sel[0]`→s0.
- Also drives a one-hot grant back to the requesters.
- Each grant lasts until the requester drops its request or a programmable hold limit expires, whichever comes first.

Parameters:
- HOLD_W, 4, width of `hold_len`; maximum grant length is 2^HOLD_W-1 cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scheduler enable; low means no new grants and any active grant is terminated.
- req  input  8  request per mux input; bit i corresponds to mux data input i (a=0 … h=7).
- hold_len  input  HOLD_W  maximum grant length in cycles; 0 is treated as 1; sampled only when a grant starts.
- gnt  output  8  one-hot grant, registered; all-zero when no grant is active.
- sel  output  3  mux select = index of the granted requester, registered.
- sel_valid  output  1  high while a grant is active (equals |gnt).
- grant_start  output  1  single-cycle pulse in the first cycle of every grant, including back-to-back and re-grants.

Behaviour:
Reset:
- `rst_n` low asynchronously clears all state: `gnt`=0, `sel`=0, `sel_valid`=0, `grant_start`=0, priority pointer `ptr`=0, hold counter=0, state IDLE.
- Reset mid-grant drops the grant immediately, without waiting for a clock edge.

Arbitration function (combinational):
- Search `req` circularly in ascending index starting at `ptr` (ptr, ptr+1, …, 7, 0, …).
- The first set bit is the winner; no winner if `req`==0.

State IDLE:
- Transition: if `en`=1 and `req`!=0 at an edge → GRANT.
- Actions at that edge: `gnt`=onehot(winner), `sel`=winner, `sel_valid`=1, `grant_start`=1, `cnt`=1, `limit`=max(`hold_len`,1).
- Request-to-grant latency: 1 cycle.

State GRANT (granted index g):
- Release condition at an edge: `req[g]`=0, OR `cnt`==`limit`, OR `en`=0.
- If no release: `cnt`++, `grant_start`=0, all outputs otherwise held.
- On release:
  - `ptr` := (g+1) mod 8.
  - Re-arbitrate in the same edge using the new `ptr` and the current `req` (excluding `req` entirely when `en`=0).
  - Winner found: new grant with no idle gap; `grant_start`=1, `cnt`=1, `limit` re-sampled. If g is still the only requester, it is re-granted.
  - No winner, or `en`=0: → IDLE with `gnt`=0, `sel_valid`=0, `grant_start`=0.

Output rules:
- `sel` changes only at grant edges and holds its last value while in IDLE.
- `gnt` and `sel` are always mutually consistent.
- `gnt` never has more than one bit set.

Boundary conditions:
- Requests arriving mid-grant have no effect until the current release.
- `hold_len` changes during a grant are ignored.
- `ptr` wraps from 7 to 0.
- `cnt` never exceeds `limit`; no overflow is possible.
- `req[g]` dropping in the same cycle that `cnt`==`limit` is a single release event.

Test Plan:
1. Reset mid-grant:
   - Stimulus: assert `rst_n`=0 while `gnt`=0x10.
   - Required: `gnt`=0, `sel`=0, `sel_valid`=0 immediately, before any clock edge.
   - Then release reset and apply `req`=0x01: `gnt`=0x01, `sel`=0, `grant_start`=1 after one edge.
2. Single requester with hold limit:
   - Stimulus: `req`=0x08 constant, `hold_len`=3, `en`=1.
   - Required: `gnt`=0x08, `sel`=3 for 3 cycles; `grant_start` pulses on cycle 1 and again on cycle 4 (re-grant); `sel_valid` never drops.
3. Full contention:
   - Stimulus: `req`=0xFF, `hold_len`=1.
   - Required: `sel` sequence 0,1,2,…,7,0,1 on consecutive cycles; `grant_start`=1 every cycle; `sel_valid`=1 continuously.
4. Early release:
   - Stimulus: `req`=0x24, `hold_len`=4; grant to 2 at edge k; clear `req[2]` before edge k+2.
   - Required: `gnt`=0x04 for 2 cycles, then `gnt`=0x20 and `sel`=5 from edge k+2 with no gap.
5. Pointer wrap:
   - Stimulus: `req`=0x80, `hold_len`=1 → `gnt`=0x80; then `req`=0x81.
   - Required: next grant is `gnt`=0x01, `sel`=0 (ptr wrapped to 0), followed by 0x80.
6. `hold_len`=0 and enable drop:
   - Stimulus: `hold_len`=0, `req`=0x02.
   - Required: each grant lasts exactly 1 cycle.
   - Stimulus: set `hold_len`=7 and drop `en` in cycle 2 of a grant.
   - Required: `gnt`=0, `sel_valid`=0 at the next edge; no new grant while `en`=0.
